// File: rtl/riscv_types.sv
// Shared type definitions for the elastic pipeline stage.
package riscv_types;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } elastic_state_t;

  // The state encoding equals the entry count, so occupancy is the state itself.
  function automatic logic [1:0] occupancy_of(elastic_state_t s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/n_bit_reg_wclr.sv
// N-bit payload register with write enable and a synchronous clear that wins over the write.
module n_bit_reg_wclr #(
  parameter int           N           = 32,
  parameter logic [N-1:0] RESET_VALUE = '0,
  parameter logic [N-1:0] CLR_VALUE   = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         wen,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] q_d;
  logic [N-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (clear) begin
      q_d = CLR_VALUE;
    end else if (wen) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/elastic_pipe_reg.sv
// Elastic valid/ready pipeline register: one-entry (SKID=0) or two-entry skid (SKID=1).
// Handshake: a beat transfers on a rising edge where valid and ready are both high;
// in_ready is registered and never depends on out_ready in the same cycle.
module elastic_pipe_reg
  import riscv_types::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               SKID        = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] CLR_VALUE   = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [1:0]       occupancy
);

  elastic_state_t   state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             in_fire, out_fire;
  logic             main_wen, skid_wen, main_from_skid;
  logic [WIDTH-1:0] main_d, main_q, skid_q;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = (state_q != EMPTY) & out_ready;

  always_comb begin
    state_d        = state_q;
    main_wen       = 1'b0;
    skid_wen       = 1'b0;
    main_from_skid = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_wen = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (SKID != 0) begin
          if (in_fire && out_fire) begin
            main_wen = 1'b1;
          end else if (in_fire) begin
            skid_wen = 1'b1;
            state_d  = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_wen       = 1'b1;
          main_from_skid = 1'b1;
          state_d        = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush discards everything, including a handshake completing this cycle.
    if (flush) begin
      state_d  = EMPTY;
      main_wen = 1'b0;
      skid_wen = 1'b0;
    end
    in_ready_d = (SKID != 0) ? (state_d != FULL) : (state_d == EMPTY);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  n_bit_reg_wclr #(
    .N           (WIDTH),
    .RESET_VALUE (RESET_VALUE),
    .CLR_VALUE   (CLR_VALUE)
  ) u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (flush),
    .wen     (main_wen),
    .d       (main_d),
    .q       (main_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      n_bit_reg_wclr #(
        .N           (WIDTH),
        .RESET_VALUE (RESET_VALUE),
        .CLR_VALUE   (CLR_VALUE)
      ) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (flush),
        .wen     (skid_wen),
        .d       (in_data),
        .q       (skid_q)
      );
    end else begin : g_no_skid
      assign skid_q = CLR_VALUE;
    end
  endgenerate

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = occupancy_of(state_q);

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Bench for elastic_pipe_reg: a SKID=1 and a SKID=0 instance share stimulus, each with its own queue scoreboard.
module tb_elastic_pipe_reg;

  localparam int          W      = 32;
  localparam logic [31:0] RST_V  = 32'h1234_5678;
  localparam logic [31:0] CLR_V  = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid, out_ready, flush;
  logic [W-1:0]  in_data;
  logic          in_ready1, out_valid1, in_ready0, out_valid0;
  logic [W-1:0]  out_data1, out_data0;
  logic [1:0]    occ1, occ0;

  logic [W-1:0]  exp_q1[$];
  logic [W-1:0]  exp_q0[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int out_cnt[2];
  int first_cyc[2];
  int last_cyc[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  elastic_pipe_reg #(.WIDTH(W), .SKID(1), .RESET_VALUE(RST_V), .CLR_VALUE(CLR_V)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready), .flush(flush), .occupancy(occ1)
  );

  elastic_pipe_reg #(.WIDTH(W), .SKID(0), .RESET_VALUE(RST_V), .CLR_VALUE(CLR_V)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
    .out_valid(out_valid0), .out_data(out_data0), .out_ready(out_ready), .flush(flush), .occupancy(occ0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: a FIFO of capacity 2 (SKID=1) or 1 (SKID=0); flush and reset empty it.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q1.delete();
    end else begin
      check("occ1", 32'(occ1), 32'(exp_q1.size()));
      check("out_valid1", 32'(out_valid1), 32'(exp_q1.size() != 0));
      check("in_ready1", 32'(in_ready1), 32'(exp_q1.size() < 2));
      if (flush) begin
        exp_q1.delete();
      end else begin
        if (out_valid1 && out_ready) begin
          if (exp_q1.size() == 0) check("pop_empty1", 32'(out_valid1), 32'd0);
          else check("out_data1", out_data1, exp_q1.pop_front());
          if (out_cnt[1] == 0) first_cyc[1] = cyc;
          last_cyc[1] = cyc;
          out_cnt[1]++;
        end
        if (in_valid && in_ready1) exp_q1.push_back(in_data);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q0.delete();
    end else begin
      check("occ0", 32'(occ0), 32'(exp_q0.size()));
      check("out_valid0", 32'(out_valid0), 32'(exp_q0.size() != 0));
      check("in_ready0", 32'(in_ready0), 32'(exp_q0.size() == 0));
      if (flush) begin
        exp_q0.delete();
      end else begin
        if (out_valid0 && out_ready) begin
          if (exp_q0.size() == 0) check("pop_empty0", 32'(out_valid0), 32'd0);
          else check("out_data0", out_data0, exp_q0.pop_front());
          if (out_cnt[0] == 0) first_cyc[0] = cyc;
          last_cyc[0] = cyc;
          out_cnt[0]++;
        end
        if (in_valid && in_ready0) exp_q0.push_back(in_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  task automatic stream(input int sel, input int n);
    int  k;
    int  guard;
    logic fire;
    k = 0;
    guard = 0;
    out_cnt[sel] = 0;
    out_ready = 1'b1;
    flush = 1'b0;
    while (k < n && guard < 1000) begin
      in_valid = 1'b1;
      in_data  = k;
      @(negedge clk);
      fire = (sel == 1) ? in_ready1 : in_ready0;
      tick();
      if (fire) k++;
      guard++;
    end
    in_valid = 1'b0;
    guard = 0;
    while (out_cnt[sel] < n && guard < 50) begin
      tick();
      guard++;
    end
    check($sformatf("stream_count%0d", sel), out_cnt[sel], n);
    check($sformatf("stream_span%0d", sel), last_cyc[sel] - first_cyc[sel],
          (sel == 1) ? n - 1 : 2 * n - 2);
    out_ready = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r1, r0;
    reset_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    @(negedge clk);
    check("rst_in_ready", 32'(in_ready1), 32'd1);
    check("rst_out_valid", 32'(out_valid1), 32'd0);
    check("rst_occ", 32'(occ1), 32'd0);
    check("rst_out_data", out_data1, RST_V);

    // Single push with the consumer stalled.
    tick();
    drive(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("push1_valid", 32'(out_valid1), 32'd1);
    check("push1_occ", 32'(occ1), 32'd1);
    check("push1_in_ready", 32'(in_ready1), 32'd1);
    check("push1_data", out_data1, 32'hA5A5_0001);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Two pushes fill both slots, then drain in order.
    drive(1'b1, 32'h1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h2, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("full_occ", 32'(occ1), 32'd2);
    check("full_in_ready", 32'(in_ready1), 32'd0);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("drain_first", out_data1, 32'h1);
    tick();
    @(negedge clk);
    check("drain_second", out_data1, 32'h2);
    tick();
    @(negedge clk);
    check("drain_empty", 32'(out_valid1), 32'd0);
    tick();
    out_ready = 1'b0;

    // Flush while full with a consumer ready: nothing is consumed.
    drive(1'b1, 32'h7, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h8, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    check("flush_occ", 32'(occ1), 32'd0);
    check("flush_out_valid", 32'(out_valid1), 32'd0);
    check("flush_in_ready", 32'(in_ready1), 32'd1);
    check("flush_out_data", out_data1, CLR_V);
    check("flush_out_data0", out_data0, CLR_V);
    tick();

    stream(1, 100);
    stream(0, 100);

    // Asynchronous reset while full.
    drive(1'b1, 32'hCAFE_0001, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hCAFE_0002, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("async_occ", 32'(occ1), 32'd0);
    check("async_out_valid", 32'(out_valid1), 32'd0);
    check("async_in_ready", 32'(in_ready1), 32'd1);
    check("async_out_data", out_data1, RST_V);
    @(negedge clk);
    tick();
    reset_n = 1'b1;

    // Random traffic with occasional flush; probe in_ready against out_ready toggles.
    for (int i = 0; i < 10000; i++) begin
      drive($urandom_range(0, 1), $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
      if (i % 8 == 0) begin
        #1;
        r1 = in_ready1;
        r0 = in_ready0;
        out_ready = ~out_ready;
        #1;
        check("in_ready1_indep", 32'(in_ready1), 32'(r1));
        check("in_ready0_indep", 32'(in_ready0), 32'(r0));
        out_ready = ~out_ready;
      end
      tick();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
